eth_rx_fcs_check: RTL and testbench
===================================

// Module: eth_rx_fcs_check
// PURPOSE
//  Receive-side counterpart of the Ethernet TX CRC32 path. Takes raw GMII RX bytes, strips preamble/SFD,
//  runs CRC32 over frame bytes + FCS and forwards the frame body without its 4 FCS bytes.
//  Issues one end-of-frame verdict: good, FCS error, length error, PHY error. Sits between the
//  GMII RX pins and the ARP/UDP RX parsers.
// PARAMETERS
//  MIN_LEN   64    minimum frame length in bytes, DA..FCS inclusive; shorter = runt
//  MAX_LEN   1518  maximum frame length in bytes, DA..FCS inclusive; longer = oversize
//  PRE_MIN   1     minimum count of 0x55 bytes required before SFD 0xD5
// PORTS
//  clk          in   1  GMII RX clock; all logic on posedge
//  rst_n        in   1  reset, synchronous, active-low
//  gmii_rx_dv   in   1  receive data valid
//  gmii_rx_er   in   1  PHY receive error
//  gmii_rxd     in   8  receive byte
//  out_valid    out  1  out_data valid this cycle
//  out_sof      out  1  first body byte (DA[0]); qualified by out_valid
//  out_data     out  8  frame body byte, FCS excluded
//  frame_done   out  1  one-cycle pulse: frame ended, verdict valid
//  frame_ok     out  1  valid with frame_done: err_code==0
//  err_code     out  3  valid with frame_done: [0] FCS bad, [1] length bad, [2] rx_er seen
// BEHAVIOUR
//  Reset
//  - All outputs 0. State=SYNC. CRC register=32'hFFFF_FFFF. Counters=0. Delay line cleared.
//  - Reset may assert mid-frame; the rest of that frame is ignored.
//  Input stage
//  - gmii_* are registered once (d1). The FSM acts only on d1 values.
//  FSM
//  - SYNC: wait for dv_d1=0, then go to IDLE. Never start a frame mid-stream.
//  - IDLE: if dv_d1=1 and rxd_d1=0x55, set pre_cnt=1 and go to PREAMBLE.
//    If dv_d1=1 with any other byte, go to DROP.
//  - PREAMBLE:
//    - 0x55: pre_cnt++ (saturate at 7).
//    - 0xD5 with pre_cnt>=PRE_MIN: clear CRC to all-ones and byte_cnt to 0, go to DATA.
//    - Any other byte, 0xD5 with pre_cnt<PRE_MIN, or rx_er=1: go to DROP.
//    - dv_d1=0: go to IDLE. No frame_done.
//  - DATA, each cycle with dv_d1=1:
//    - Feed the byte to the CRC; byte_cnt++ (11 bits, saturate at 2047).
//    - Push the byte into a 4-deep shift line.
//    - rx_er=1 sets sticky er_flag.
//    - When byte_cnt>MAX_LEN: stop forwarding and set sticky len_flag; keep CRC running.
//  - DATA with dv_d1=0: go to IDLE. In that same cycle pulse frame_done and drive the verdict
//    from the state as it stood at the end of the last byte:
//    - err[0] = (CRC register != CRC_RESIDUE)
//    - err[1] = (byte_cnt<MIN_LEN) | len_flag
//    - err[2] = er_flag
//    - Clear the delay line; no further out_valid.
//  - DROP: wait for dv_d1=0, then go to IDLE. No outputs in DROP.
//  Forwarding
//  - When a byte is pushed into the full shift line, the oldest byte pops out: out_valid=1, out_data=it.
//  - out_sof=1 on the first pop of a frame.
//  - Body byte n is output in the cycle after byte n+4 is registered. The final 4 bytes (FCS)
//    are never output.
//  CRC
//  - Input bytes are bit-reversed before the step function (GMII LSB-first wire order).
//  - Register init is all-ones. No final inversion in the register.
//  - A correct frame leaves CRC_RESIDUE = 32'hC704_DD7B after the last FCS byte.
//  Boundaries
//  - Back-to-back frames separated by a single dv=0 cycle are supported; IDLE accepts 0x55 next cycle.
//  - Frames of 4 or fewer bytes: no out_valid; verdict err[1]=1.
//  - At most one frame_done per frame.
// STRUCTURE
//  - Shared package eth_pkg: CRC32_INIT, CRC_RESIDUE, SFD=8'hD5, PRE=8'h55, state enum
//    {SYNC,IDLE,PREAMBLE,DATA,DROP}, function crc32_d8_next(crc,data) shared with the TX CRC.
//  - One sub-module: eth_rx_dly4 (4-byte shift line, push/clear, pop-valid output).
//  - FSM, counters and verdict logic stay in this module.
// TESTING
//  - Good frame: 7x55, D5, 60 bytes 0x00..0x3B, correct FCS -> 60 out_valid bytes 0x00..0x3B,
//    out_sof on 0x00, frame_done with frame_ok=1, err=000.
//  - Same frame with byte 10 flipped to 0xFF -> 60 bytes forwarded, frame_done with err=001, frame_ok=0.
//  - 40-byte body + valid FCS -> err=010. Then 1519+ bytes -> forwarding stops at byte 1514, err=010 (or 011).
//  - rx_er pulsed at body byte 20 of the good frame -> err=100. rx_er in preamble -> no frame_done.
//  - Preamble 55 55 55 00 ... -> DROP: no out_valid, no frame_done. The next good frame is accepted normally.
//  - rst_n low for 1 cycle mid-DATA with dv held high -> SYNC, no output until dv drops.
//    Two back-to-back good frames with a 1-cycle gap -> two frame_ok pulses.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the TX CRC and RX FCS paths.
//   CRC32_INIT / CRC_RESIDUE : CRC register seed and the good-frame remainder
//   PRE / SFD                : preamble and start-of-frame delimiter bytes
//   rx_state_t               : receive FSM states
//   bit_rev8                 : byte bit reversal (GMII carries bytes LSB first)
//   crc32_d8_next            : one-byte MSB-first CRC32 step, poly 0x04C11DB7
package eth_pkg;

  localparam logic [31:0] CRC32_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC32_POLY  = 32'h04C1_1DB7;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [7:0]  PRE         = 8'h55;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Feeds data[7] first; callers pass the bit-reversed wire byte so the
  // first bit on the wire enters the register first.
  function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc,
                                                input logic [7:0]  data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_dly4.sv
// Four-byte shift line that holds back the trailing FCS of a frame.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : shift a byte in
//   clear      : empty the line and re-arm the start-of-frame marker
//   pop_valid  : registered; oldest byte left the full line this cycle
//   pop_sof    : registered; first pop since the last clear
//   pop_data   : registered popped byte
module eth_rx_dly4
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       clear,
  input  logic [7:0] din,
  output logic       pop_valid,
  output logic       pop_sof,
  output logic [7:0] pop_data
);

  logic [7:0] line [4];
  logic [2:0] fill;
  logic       first;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < 4; i++) line[i] <= 8'h00;
      fill      <= 3'd0;
      first     <= 1'b1;
      pop_valid <= 1'b0;
      pop_sof   <= 1'b0;
      pop_data  <= 8'h00;
    end else begin
      pop_valid <= 1'b0;
      pop_sof   <= 1'b0;
      if (push) begin
        line[0] <= din;
        for (int i = 1; i < 4; i++) line[i] <= line[i-1];
        if (fill == 3'd4) begin
          pop_valid <= 1'b1;
          pop_sof   <= first;
          pop_data  <= line[3];
          first     <= 1'b0;
        end else begin
          fill <= fill + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// GMII receive front end: strips preamble/SFD, checks FCS and length,
// forwards the frame body without its FCS and issues one verdict per frame.
//   clk, rst_n                       : GMII RX clock, synchronous active-low reset
//   gmii_rx_dv, gmii_rx_er, gmii_rxd : raw GMII receive inputs
//   out_valid, out_sof, out_data     : body byte stream (DA first, FCS removed)
//   frame_done                       : one-cycle end-of-frame pulse
//   frame_ok, err_code               : verdict with frame_done ([0] FCS, [1] length, [2] rx_er)
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int PRE_MIN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [7:0] gmii_rxd,
  output logic       out_valid,
  output logic       out_sof,
  output logic [7:0] out_data,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [2:0] err_code
);

  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
  localparam logic [2:0]  PRE_MIN_C = 3'(PRE_MIN);

  logic        dv_d1, er_d1;
  logic [7:0]  rxd_d1;
  rx_state_t   state, state_next;
  logic [2:0]  pre_cnt;
  logic [31:0] crc;
  logic [10:0] byte_cnt, cnt_next;
  logic        er_flag, len_flag;
  logic        pre_start, pre_inc, sfd_ok, data_byte, frame_end, fwd;
  logic [2:0]  err_now;

  // Input register deliberately has no reset: it keeps tracking the pins
  // during reset so SYNC sees dv still high when reset drops mid-frame.
  always_ff @(posedge clk) begin
    dv_d1  <= gmii_rx_dv;
    er_d1  <= gmii_rx_er;
    rxd_d1 <= gmii_rxd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC:     if (!dv_d1) state_next = IDLE;
      IDLE:     if (dv_d1) state_next = (rxd_d1 == PRE) ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!dv_d1)                                  state_next = IDLE;
        else if (er_d1)                              state_next = DROP;
        else if (rxd_d1 == PRE)                      state_next = PREAMBLE;
        else if (rxd_d1 == SFD && pre_cnt >= PRE_MIN_C) state_next = DATA;
        else                                         state_next = DROP;
      end
      DATA:     if (!dv_d1) state_next = IDLE;
      DROP:     if (!dv_d1) state_next = IDLE;
      default:  state_next = SYNC;
    endcase
  end

  always_comb begin
    pre_start = (state == IDLE) && dv_d1 && (rxd_d1 == PRE);
    pre_inc   = (state == PREAMBLE) && dv_d1 && !er_d1 && (rxd_d1 == PRE);
    sfd_ok    = (state == PREAMBLE) && (state_next == DATA);
    data_byte = (state == DATA) && dv_d1;
    frame_end = (state == DATA) && !dv_d1;
    // Forwarding stops once the frame exceeds MAX_LEN; the line is no longer
    // fed, so nothing more pops out for this frame.
    fwd       = data_byte && (cnt_next <= MAX_LEN_C);
  end

  assign cnt_next = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign err_now  = {er_flag, (byte_cnt < MIN_LEN_C) | len_flag, crc != CRC_RESIDUE};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt    <= 3'd0;
      crc        <= CRC32_INIT;
      byte_cnt   <= 11'd0;
      er_flag    <= 1'b0;
      len_flag   <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= 3'd0;
    end else begin
      if (pre_start)                     pre_cnt <= 3'd1;
      else if (pre_inc && pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;

      if (sfd_ok) begin
        crc      <= CRC32_INIT;
        byte_cnt <= 11'd0;
        er_flag  <= 1'b0;
        len_flag <= 1'b0;
      end else if (data_byte) begin
        crc      <= crc32_d8_next(crc, bit_rev8(rxd_d1));
        byte_cnt <= cnt_next;
        if (er_d1)                  er_flag  <= 1'b1;
        if (cnt_next > MAX_LEN_C)   len_flag <= 1'b1;
      end

      frame_done <= frame_end;
      frame_ok   <= frame_end && (err_now == 3'd0);
      err_code   <= frame_end ? err_now : 3'd0;
    end
  end

  eth_rx_dly4 u_dly4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fwd),
    .clear     (sfd_ok | frame_end),
    .din       (rxd_d1),
    .pop_valid (out_valid),
    .pop_sof   (out_sof),
    .pop_data  (out_data)
  );

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check with a frame-level reference model.
module tb_eth_rx_fcs_check;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gmii_rx_dv = 1'b0;
  logic       gmii_rx_er = 1'b0;
  logic [7:0] gmii_rxd = 8'h00;
  logic       out_valid, out_sof, frame_done, frame_ok;
  logic [7:0] out_data;
  logic [2:0] err_code;

  always #5 clk = ~clk;

  eth_rx_fcs_check dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .gmii_rxd   (gmii_rxd),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_data   (out_data),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_code   (err_code)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
  } out_t;

  int         checks = 0;
  int         errors = 0;
  int         n_valid = 0;
  int         n_ok = 0;
  out_t       exp_out[$];
  logic [2:0] exp_done[$];
  logic [7:0] body[$];
  logic [7:0] wire_d[$];
  bit         wire_e[$];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endfunction

  // Reflected (LSB-first) CRC32 as used on the wire.
  function automatic logic [31:0] crc_refl(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  function automatic void set_body(input int n, input int mul);
    body.delete();
    for (int i = 0; i < n; i++) body.push_back(8'((i * mul) & 255));
  endfunction

  function automatic void make_wire(input int npre, input bit add_fcs);
    logic [31:0] c;
    wire_d.delete();
    wire_e.delete();
    repeat (npre) wire_d.push_back(8'h55);
    wire_d.push_back(8'hD5);
    c = 32'hFFFF_FFFF;
    foreach (body[k]) begin
      wire_d.push_back(body[k]);
      c = crc_refl(c, body[k]);
    end
    if (add_fcs) begin
      c = ~c;
      for (int b = 0; b < 4; b++) wire_d.push_back(c[8*b +: 8]);
    end
    while (wire_e.size() < wire_d.size()) wire_e.push_back(1'b0);
  endfunction

  // Parses one dv burst the way a receiver must and queues the expected
  // body bytes and verdict. Returns the verdict, or -1 if no frame results.
  function automatic int model_burst();
    int          i, n, nfwd;
    logic [31:0] c;
    bit          er_seen;
    logic [2:0]  err;
    if (wire_d.size() == 0 || wire_d[0] != 8'h55) return -1;
    i = 1;
    while (i < wire_d.size() && wire_d[i] == 8'h55 && !wire_e[i]) i++;
    if (i >= wire_d.size() || wire_e[i] || wire_d[i] != 8'hD5) return -1;
    n = wire_d.size() - i - 1;
    c = 32'hFFFF_FFFF;
    er_seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      c = crc_refl(c, wire_d[i+1+k]);
      er_seen |= wire_e[i+1+k];
    end
    nfwd = (n > 4) ? (((n - 4) > 1514) ? 1514 : (n - 4)) : 0;
    for (int k = 0; k < nfwd; k++) exp_out.push_back('{d: wire_d[i+1+k], sof: (k == 0)});
    err = {er_seen, (n < 64) || (n > 1518), c != 32'hDEBB_20E3};
    exp_done.push_back(err);
    return int'(err);
  endfunction

  task automatic drive_byte(input logic [7:0] d, input bit e);
    @(posedge clk);
    #1;
    gmii_rx_dv = 1'b1;
    gmii_rxd   = d;
    gmii_rx_er = e;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      gmii_rxd   = 8'h00;
    end
  endtask

  task automatic send(input string name, input int want, input int gap);
    int got;
    got = model_burst();
    $display("burst %s: %0d wire bytes, model verdict %0d", name, wire_d.size(), got);
    check({"model_", name}, 32'(got), 32'(want));
    for (int k = 0; k < wire_d.size(); k++) drive_byte(wire_d[k], wire_e[k]);
    idle(gap);
  endtask

  task automatic drained(input string name);
    check({name, "_bytes_left"}, 32'(exp_out.size()), 32'd0);
    check({name, "_verdicts_left"}, 32'(exp_done.size()), 32'd0);
  endtask

  // Compare process: every cycle outputs are meaningful.
  always @(negedge clk) begin
    out_t e;
    logic [2:0] v;
    if (out_valid === 1'b1) begin
      n_valid++;
      if (exp_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got data %0h, required no output", out_data);
      end else begin
        e = exp_out.pop_front();
        check("out_data", 32'(out_data), 32'(e.d));
        check("out_sof", 32'(out_sof), 32'(e.sof));
      end
    end
    if (frame_done === 1'b1) begin
      $display("frame_done err_code=%b frame_ok=%b", err_code, frame_ok);
      if (frame_ok) n_ok++;
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got err %b, required no verdict", err_code);
      end else begin
        v = exp_done.pop_front();
        check("err_code", 32'(err_code), 32'(v));
        check("frame_ok", 32'(frame_ok), 32'(v == 3'd0));
      end
    end
  end

  initial begin
    int nv0, ok0;
    logic [31:0] c;
    logic [7:0] s [9];

    // Model pin: CRC-32 of "123456789" is CBF43926.
    for (int i = 0; i < 9; i++) s[i] = 8'(8'h31 + i);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) c = crc_refl(c, s[i]);
    check("model_crc_123456789", ~c, 32'hCBF4_3926);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sof", 32'(out_sof), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_ok", 32'(frame_ok), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    // Good 64-byte frame.
    nv0 = n_valid;
    set_body(60, 1);
    make_wire(7, 1);
    send("good", 0, 10);
    check("good_byte_count", 32'(n_valid - nv0), 32'd60);
    check("good_ok_count", 32'(n_ok), 32'd1);
    drained("good");

    // Corrupted body byte 10.
    make_wire(7, 1);
    wire_d[8+10] = 8'hFF;
    send("fcs_bad", 1, 10);
    drained("fcs_bad");

    // Runt: 40-byte body + FCS.
    set_body(40, 3);
    make_wire(7, 1);
    send("runt", 2, 10);
    drained("runt");

    // FCS only: nothing forwarded.
    nv0 = n_valid;
    set_body(0, 1);
    make_wire(7, 1);
    send("fcs_only", 2, 10);
    check("fcs_only_bytes", 32'(n_valid - nv0), 32'd0);
    drained("fcs_only");

    // rx_er on body byte 20.
    set_body(60, 1);
    make_wire(7, 1);
    wire_e[8+20] = 1'b1;
    send("rx_er", 4, 10);
    drained("rx_er");

    // rx_er in preamble: dropped.
    make_wire(7, 1);
    wire_e[3] = 1'b1;
    send("er_pre", -1, 10);
    drained("er_pre");

    // Bad preamble then good frame.
    set_body(20, 5);
    make_wire(3, 1);
    wire_d[3] = 8'h00;
    send("bad_pre", -1, 4);
    set_body(60, 1);
    make_wire(1, 1);
    send("after_drop", 0, 10);
    drained("bad_pre");

    // Exactly MAX_LEN: all body bytes forwarded, good.
    nv0 = n_valid;
    set_body(1514, 7);
    make_wire(7, 1);
    send("max_len", 0, 10);
    check("max_len_bytes", 32'(n_valid - nv0), 32'd1514);
    drained("max_len");

    // Oversize 1520 bytes: forwarding stops after 1514 bytes.
    nv0 = n_valid;
    set_body(1516, 3);
    make_wire(7, 1);
    send("oversize", 2, 10);
    check("oversize_bytes", 32'(n_valid - nv0), 32'd1514);
    drained("oversize");

    // Back-to-back frames with a single idle cycle.
    ok0 = n_ok;
    set_body(60, 1);
    make_wire(7, 1);
    send("b2b_1", 0, 1);
    set_body(64, 9);
    make_wire(7, 1);
    send("b2b_2", 0, 10);
    check("b2b_ok_count", 32'(n_ok - ok0), 32'd2);
    drained("b2b");

    // Reset mid-DATA with dv held high; a fake preamble follows before dv drops.
    set_body(60, 1);
    make_wire(7, 1);
    void'(model_burst());
    for (int k = 0; k < 30; k++) drive_byte(wire_d[k], 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    gmii_rxd = wire_d[30];
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_out.delete();
    exp_done.delete();
    nv0 = n_valid;
    ok0 = n_ok;
    gmii_rxd = wire_d[31];
    drive_byte(8'h55, 1'b0);
    drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    for (int k = 0; k < 16; k++) drive_byte(8'(k), 1'b0);
    idle(10);
    check("reset_no_output", 32'(n_valid - nv0), 32'd0);
    check("reset_no_verdict", 32'(n_ok - ok0), 32'd0);
    send("after_reset", 0, 10);
    check("after_reset_ok", 32'(n_ok - ok0), 32'd1);
    drained("reset");

    idle(20);
    drained("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
